// File: rtl/axi_slice_arb_pkg.sv
// Shared types and helpers for the round-robin AXI slice arbiter.
package axi_slice_arb_pkg;

  // Upper bound on requester count the pick helper can scan.
  localparam int unsigned MAX_REQ   = 32;
  localparam int unsigned MAX_REQ_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // First set bit of (valid & ~mask) scanning upward from start, modulo n.
  // Rotate so start lands at bit 0, priority-encode, then rotate back.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned        start,
                                          input logic [MAX_REQ-1:0] mask,
                                          input int unsigned        n);
    logic [MAX_REQ-1:0] vm;
    logic [MAX_REQ-1:0] rot;
    int unsigned        j;
    int unsigned        k;
    int unsigned        win;
    vm  = valid & ~mask;
    rot = '0;
    win = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = start + i;
        if (j >= n) j = j - n;
        rot[i[MAX_REQ_W-1:0]] = vm[j[MAX_REQ_W-1:0]];
      end
    end
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = MAX_REQ - 1 - i;
      if (k < n && rot[k[MAX_REQ_W-1:0]]) win = k;
    end
    j = start + win;
    if (j >= n) j = j - n;
    return j;
  endfunction

endpackage

// File: rtl/axi_slice_rr_arbiter_rr_pick_comb.sv
// Combinational round-robin pick: rotate, priority-encode, unrotate.
module rr_pick_comb
  import axi_slice_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int unsigned win;

  // Winner index and whether any unmasked requester is valid.
  always_comb begin
    win     = rr_pick(MAX_REQ'(valid_i), 32'(start_i), MAX_REQ'(mask_i), NUM_REQ);
    idx_o   = IDX_W'(win);
    found_o = |(valid_i & ~mask_i);
  end

endmodule

// File: rtl/axi_slice_rr_arbiter.sv
// Round-robin arbiter sharing one AXI slice channel between NUM_REQ masters,
// optionally holding the grant across a burst until the last beat.
module axi_slice_rr_arbiter
  import axi_slice_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOCK_BURST = 1,
  parameter int unsigned IDX_W      = idx_width(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]                 req_last_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic                               last_o,
  output logic [IDX_W-1:0]                   idx_o,
  output logic                               busy_o
);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0]      sel;
  logic [IDX_W-1:0]      gnt_nxt;
  logic [NUM_REQ-1:0]    gnt_mask;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  idle_found, rel_found;
  logic [IDX_W-1:0]      idle_idx, rel_idx;
  logic                  beat, rel;

  // Output mux of the granted requester; forced to index 0 while in reset.
  always_comb begin
    sel       = rst_i ? '0 : gnt_q;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    gnt_mask  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        gnt_valid = req_valid_i[i];
        gnt_last  = req_last_i[i];
        gnt_data  = req_data_i[i];
      end
      gnt_mask[i] = (gnt_q == IDX_W'(i));
    end
    gnt_nxt = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
  end

  rr_pick_comb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick_idle (
    .valid_i (req_valid_i),
    .mask_i  ('0),
    .start_i (rr_ptr_q),
    .found_o (idle_found),
    .idx_o   (idle_idx)
  );

  rr_pick_comb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick_rel (
    .valid_i (req_valid_i),
    .mask_i  (gnt_mask),
    .start_i (gnt_nxt),
    .found_o (rel_found),
    .idx_o   (rel_idx)
  );

  // Next-state, grant/pointer update and handshake outputs.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    valid_o     = 1'b0;
    req_ready_o = '0;
    busy_o      = 1'b0;
    beat        = 1'b0;
    rel         = 1'b0;
    data_o      = gnt_data;
    last_o      = gnt_last;
    idx_o       = rst_i ? '0 : gnt_q;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (idle_found) begin
            gnt_d   = idle_idx;
            state_d = BUSY;
          end
        end
        BUSY: begin
          busy_o      = 1'b1;
          valid_o     = gnt_valid;
          req_ready_o = gnt_mask & {NUM_REQ{ready_i}};
          beat        = gnt_valid & ready_i;
          rel         = beat & ((LOCK_BURST == 0) | gnt_last);
          if (rel) begin
            rr_ptr_d = gnt_nxt;
            if (rel_found) gnt_d = rel_idx;
            else           state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_axi_slice_rr_arbiter.sv
// Directed self-checking bench for axi_slice_rr_arbiter.
module tb_axi_slice_rr_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_last;
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      data_o;
  logic             last_o;
  logic [1:0]       idx_o;
  logic             busy_o;

  logic [0:0]       v1;
  logic [0:0]       r1;
  logic [0:0][31:0] d1;
  logic [0:0]       l1;
  logic             vo1;
  logic [31:0]      do1;
  logic             lo1;
  logic [0:0]       idx1;
  logic             busy1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  axi_slice_rr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .LOCK_BURST (1)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .idx_o       (idx_o),
    .busy_o      (busy_o)
  );

  axi_slice_rr_arbiter #(
    .NUM_REQ    (1),
    .DATA_WIDTH (32),
    .LOCK_BURST (0)
  ) u_one (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (v1),
    .req_ready_o (r1),
    .req_data_i  (d1),
    .req_last_i  (l1),
    .valid_o     (vo1),
    .ready_i     (ready_i),
    .data_o      (do1),
    .last_o      (lo1),
    .idx_o       (idx1),
    .busy_o      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    v1        = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'hF;
    ready_i   = 1'b1;
    v1        = '0;
    l1        = '0;
    d1        = '0;
    for (int i = 0; i < 4; i++) req_data[i] = 32'h100 * i;

    // Reset held while everyone is valid
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_idx", 32'(idx_o), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_idle_valid", 32'(valid_o), 32'h0);
    check("post_rst_idle_ready", 32'(req_ready), 32'h0);
    tick();
    check("first_grant_busy", 32'(busy_o), 32'h1);
    check("first_grant_valid", 32'(valid_o), 32'h1);

    // All valid, single-beat: strict rotation with no bubble
    for (int k = 0; k < 5; k++) begin
      check("rot_idx", 32'(idx_o), 32'(k % 4));
      check("rot_ready", 32'(req_ready), 32'(1 << (k % 4)));
      check("rot_data", data_o, 32'h100 * (k % 4));
      tick();
    end

    // Locked burst from req0 while req1 waits
    do_reset();
    req_valid   = 4'b0011;
    req_last    = '0;
    req_data[1] = 32'hB0;
    #1;
    check("burst_idle", 32'(busy_o), 32'h0);
    tick();
    for (int b = 0; b < 4; b++) begin
      req_data[0] = 32'hA0 + 32'(b);
      req_last[0] = (b == 3);
      #1;
      check("burst_idx", 32'(idx_o), 32'h0);
      check("burst_data", data_o, 32'hA0 + 32'(b));
      check("burst_ready", 32'(req_ready), 32'h1);
      tick();
    end
    req_valid = 4'b0010;
    req_last  = '0;
    #1;
    check("burst_next_idx", 32'(idx_o), 32'h1);
    check("burst_next_ready", 32'(req_ready), 32'h2);
    check("burst_next_data", data_o, 32'hB0);

    // Backpressure mid-burst
    do_reset();
    req_valid   = 4'b0001;
    req_last    = '0;
    req_data[0] = 32'hA0;
    req_data[1] = 32'hB0;
    tick();
    #1;
    check("bp_beat0", data_o, 32'hA0);
    tick();
    req_data[0] = 32'hA1;
    req_valid   = 4'b0011;
    ready_i     = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_valid", 32'(valid_o), 32'h1);
      check("bp_idx", 32'(idx_o), 32'h0);
      check("bp_data", data_o, 32'hA1);
      check("bp_ready", 32'(req_ready), 32'h0);
      tick();
    end
    ready_i = 1'b1;
    #1;
    check("bp_resume_ready", 32'(req_ready), 32'h1);
    check("bp_resume_data", data_o, 32'hA1);
    tick();
    req_data[0] = 32'hA2;
    #1;
    check("bp_beat2_idx", 32'(idx_o), 32'h0);
    tick();
    req_data[0] = 32'hA3;
    req_last[0] = 1'b1;
    #1;
    check("bp_last", 32'(last_o), 32'h1);
    tick();
    req_last = '0;
    #1;
    check("bp_release_idx", 32'(idx_o), 32'h1);

    // Pointer at 3 with req3 and req1 valid: wrap-around order
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'hF;
    tick();
    #1;
    check("rr3_setup_idx", 32'(idx_o), 32'h2);
    tick();
    req_valid = 4'b1010;
    #1;
    check("rr3_idle", 32'(busy_o), 32'h0);
    tick();
    check("rr3_first", 32'(idx_o), 32'h3);
    tick();
    check("rr3_second", 32'(idx_o), 32'h1);

    // Reset during the second beat of a burst
    do_reset();
    req_valid = 4'b0011;
    req_last  = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(req_ready), 32'h0);
    check("midrst_valid", 32'(valid_o), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_idle", 32'(busy_o), 32'h0);
    tick();
    check("midrst_regrant_idx", 32'(idx_o), 32'h0);
    check("midrst_regrant_busy", 32'(busy_o), 32'h1);

    // Single requester, no burst lock: beat, mask, back through IDLE
    do_reset();
    v1    = 1'b1;
    l1    = 1'b0;
    d1[0] = 32'h55;
    #1;
    check("one_idle", 32'(busy1), 32'h0);
    tick();
    check("one_busy", 32'(busy1), 32'h1);
    check("one_valid", 32'(vo1), 32'h1);
    check("one_ready", 32'(r1), 32'h1);
    check("one_idx", 32'(idx1), 32'h0);
    check("one_data", do1, 32'h55);
    tick();
    check("one_masked_idle", 32'(busy1), 32'h0);
    check("one_masked_ready", 32'(r1), 32'h0);
    tick();
    check("one_regrant", 32'(busy1), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
